// File: rtl/dsp38_mac_sequencer.sv
// Frame sequencer for a DSP38 in multiply-accumulate mode: streams operand pairs in,
// accumulates cfg_len products per frame, and returns the drained sum on a valid/ready port.
module dsp38_mac_sequencer #(
   parameter int A_WIDTH     = 20,
   parameter int B_WIDTH     = 18,
   parameter int Z_WIDTH     = 38,
   parameter int LEN_WIDTH   = 8,
   parameter int DSP_LATENCY = 2
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic [LEN_WIDTH-1:0] cfg_len,
   input  logic                 cfg_subtract,
   input  logic [5:0]           cfg_shift,
   input  logic                 cfg_round,
   input  logic                 cfg_saturate,
   input  logic                 cfg_unsigned_a,
   input  logic                 cfg_unsigned_b,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic [A_WIDTH-1:0]   s_a,
   input  logic [B_WIDTH-1:0]   s_b,
   output logic [A_WIDTH-1:0]   dsp_a,
   output logic [B_WIDTH-1:0]   dsp_b,
   output logic                 dsp_load_acc,
   output logic [2:0]           dsp_feedback,
   output logic                 dsp_subtract,
   output logic [5:0]           dsp_shift_right,
   output logic                 dsp_round,
   output logic                 dsp_saturate,
   output logic                 dsp_unsigned_a,
   output logic                 dsp_unsigned_b,
   input  logic [Z_WIDTH-1:0]   dsp_z,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic [Z_WIDTH-1:0]   m_z,
   output logic                 busy
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ACCUM = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_HOLD  = 2'd3;

   localparam int DW = (DSP_LATENCY < 1) ? 1 : $clog2(DSP_LATENCY + 1);
   localparam logic [DW-1:0] DRAIN_LOAD = DW'(DSP_LATENCY);

   logic [1:0]           state;
   logic [1:0]           state_nxt;
   logic [LEN_WIDTH-1:0] beat_cnt;
   logic [LEN_WIDTH-1:0] len_q;
   logic [LEN_WIDTH-1:0] cfg_len_eff;
   logic                 sub_q;
   logic [DW-1:0]        drain_cnt;
   logic                 s_ready_q;
   logic                 m_valid_q;
   logic [Z_WIDTH-1:0]   m_z_q;
   logic                 hs;
   logic                 last_beat;

   assign hs          = s_valid & s_ready_q;
   assign cfg_len_eff = (cfg_len == '0) ? LEN_WIDTH'(1) : cfg_len;
   assign last_beat   = (beat_cnt == len_q - LEN_WIDTH'(1));

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (hs) state_nxt = (cfg_len_eff == LEN_WIDTH'(1)) ? ST_DRAIN : ST_ACCUM;
         ST_ACCUM: if (hs && last_beat) state_nxt = ST_DRAIN;
         ST_DRAIN: if (drain_cnt == '0) state_nxt = ST_HOLD;
         ST_HOLD:  if (m_ready) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state           <= ST_IDLE;
         beat_cnt        <= '0;
         len_q           <= '0;
         sub_q           <= 1'b0;
         drain_cnt       <= '0;
         s_ready_q       <= 1'b0;
         m_valid_q       <= 1'b0;
         m_z_q           <= '0;
         dsp_a           <= '0;
         dsp_b           <= '0;
         dsp_load_acc    <= 1'b0;
         dsp_subtract    <= 1'b0;
         dsp_shift_right <= '0;
         dsp_round       <= 1'b0;
         dsp_saturate    <= 1'b0;
         dsp_unsigned_a  <= 1'b0;
         dsp_unsigned_b  <= 1'b0;
      end else begin
         state     <= state_nxt;
         // s_ready is registered from the next state, so it reopens the cycle after a result handshake
         s_ready_q <= (state_nxt == ST_IDLE) || (state_nxt == ST_ACCUM);

         // Bubble by default: zero operands, accumulator holds (or stays loaded with 0 when idle)
         dsp_a        <= '0;
         dsp_b        <= '0;
         dsp_load_acc <= (state != ST_IDLE);
         dsp_subtract <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (hs) begin
                  len_q           <= cfg_len_eff;
                  sub_q           <= cfg_subtract;
                  dsp_shift_right <= cfg_shift;
                  dsp_round       <= cfg_round;
                  dsp_saturate    <= cfg_saturate;
                  dsp_unsigned_a  <= cfg_unsigned_a;
                  dsp_unsigned_b  <= cfg_unsigned_b;
                  beat_cnt        <= LEN_WIDTH'(1);
                  dsp_a           <= s_a;
                  dsp_b           <= s_b;
                  dsp_load_acc    <= 1'b0;
                  if (cfg_len_eff == LEN_WIDTH'(1)) drain_cnt <= DRAIN_LOAD;
               end
            end
            ST_ACCUM: begin
               if (hs) begin
                  beat_cnt     <= beat_cnt + LEN_WIDTH'(1);
                  dsp_a        <= s_a;
                  dsp_b        <= s_b;
                  dsp_load_acc <= 1'b1;
                  dsp_subtract <= sub_q;
                  if (last_beat) drain_cnt <= DRAIN_LOAD;
               end
            end
            ST_DRAIN: begin
               if (drain_cnt == '0) begin
                  m_z_q     <= dsp_z;
                  m_valid_q <= 1'b1;
               end else begin
                  drain_cnt <= drain_cnt - DW'(1);
               end
            end
            ST_HOLD: begin
               if (m_ready) begin
                  m_valid_q <= 1'b0;
                  beat_cnt  <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign s_ready      = s_ready_q;
   assign m_valid      = m_valid_q;
   assign m_z          = m_z_q;
   assign dsp_feedback = 3'b000;
   assign busy         = (state != ST_IDLE);

endmodule

// File: tb/tb_dsp38_mac_sequencer.sv
// Self-checking bench for dsp38_mac_sequencer: a DSP38 MAC model closes the loop and
// frame sums are predicted arithmetically from the queued operands.
module tb_dsp38_mac_sequencer;

   logic        CLK;
   logic        RESET;
   logic [7:0]  cfg_len;
   logic        cfg_subtract;
   logic [5:0]  cfg_shift;
   logic        cfg_round;
   logic        cfg_saturate;
   logic        cfg_unsigned_a;
   logic        cfg_unsigned_b;
   logic        s_valid;
   logic        s_ready;
   logic [19:0] s_a;
   logic [17:0] s_b;
   logic [19:0] dsp_a;
   logic [17:0] dsp_b;
   logic        dsp_load_acc;
   logic [2:0]  dsp_feedback;
   logic        dsp_subtract;
   logic [5:0]  dsp_shift_right;
   logic        dsp_round;
   logic        dsp_saturate;
   logic        dsp_unsigned_a;
   logic        dsp_unsigned_b;
   logic [37:0] dsp_z;
   logic        m_valid;
   logic        m_ready;
   logic [37:0] m_z;
   logic        busy;

   int checks = 0;
   int errors = 0;
   logic [19:0] qa[$];
   logic [17:0] qb[$];
   logic [37:0] last_z;

   dsp38_mac_sequencer #(
      .A_WIDTH(20), .B_WIDTH(18), .Z_WIDTH(38), .LEN_WIDTH(8), .DSP_LATENCY(2)
   ) dut (
      .CLK(CLK), .RESET(RESET),
      .cfg_len(cfg_len), .cfg_subtract(cfg_subtract), .cfg_shift(cfg_shift),
      .cfg_round(cfg_round), .cfg_saturate(cfg_saturate),
      .cfg_unsigned_a(cfg_unsigned_a), .cfg_unsigned_b(cfg_unsigned_b),
      .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
      .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_load_acc(dsp_load_acc),
      .dsp_feedback(dsp_feedback), .dsp_subtract(dsp_subtract),
      .dsp_shift_right(dsp_shift_right), .dsp_round(dsp_round),
      .dsp_saturate(dsp_saturate), .dsp_unsigned_a(dsp_unsigned_a),
      .dsp_unsigned_b(dsp_unsigned_b), .dsp_z(dsp_z),
      .m_valid(m_valid), .m_ready(m_ready), .m_z(m_z), .busy(busy)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // DSP38 multiply-accumulate model: input register stage, then accumulator/output register
   logic [19:0]        ar;
   logic [17:0]        br;
   logic               la_r, sub_r;
   logic [37:0]        acc;
   logic signed [37:0] ae, be, prod;

   always_comb begin
      ae   = dsp_unsigned_a ? {18'b0, ar} : {{18{ar[19]}}, ar};
      be   = dsp_unsigned_b ? {20'b0, br} : {{20{br[17]}}, br};
      prod = ae * be;
   end

   always_ff @(posedge CLK) begin
      ar    <= dsp_a;
      br    <= dsp_b;
      la_r  <= dsp_load_acc;
      sub_r <= dsp_subtract;
      acc   <= la_r ? (sub_r ? acc - prod : acc + prod) : prod;
   end
   assign dsp_z = acc;

   function automatic logic [37:0] ref_result(input int n, input bit sub, input bit ua, input bit ub);
      longint s = 0;
      for (int i = 0; i < n; i++) begin
         longint av, bv, p;
         av = ua ? longint'(qa[i]) : longint'(signed'(qa[i]));
         bv = ub ? longint'(qb[i]) : longint'(signed'(qb[i]));
         p  = av * bv;
         if (i == 0) s = p;
         else if (sub) s = s - p;
         else s = s + p;
      end
      return 38'(s);
   endfunction

   task automatic run_frame(input string name, input int gap_at, input int gap_n,
                            input bit rand_gaps, input int hold_n, input bit scramble_cfg);
      int n, wait_cnt, lat;
      logic [37:0] exp_z;
      logic [5:0]  f_shift;
      logic [4:0]  f_flags;
      n       = (cfg_len == 0) ? 1 : int'(cfg_len);
      exp_z   = ref_result(n, cfg_subtract, cfg_unsigned_a, cfg_unsigned_b);
      f_shift = cfg_shift;
      f_flags = {cfg_round, cfg_saturate, cfg_unsigned_a, cfg_unsigned_b, 1'b0};
      for (int i = 0; i < n; i++) begin
         if (rand_gaps) repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
         s_valid = 1'b1; s_a = qa[i]; s_b = qb[i];
         wait_cnt = 0;
         while (!s_ready && wait_cnt < 100) begin @(posedge CLK); #1; wait_cnt++; end
         checks++;
         if (wait_cnt >= 100) begin
            errors++;
            $display("FAIL %s accept_timeout beat %0d: s_ready stayed %b, required 1", name, i, s_ready);
         end
         @(posedge CLK); #1;
         s_valid = 1'b0;
         if (i == 0 && scramble_cfg) begin
            cfg_len = 8'($urandom); cfg_subtract = 1'($urandom); cfg_shift = 6'($urandom);
            cfg_round = 1'($urandom); cfg_saturate = 1'($urandom);
            cfg_unsigned_a = 1'($urandom); cfg_unsigned_b = 1'($urandom);
         end
         if (i == gap_at) repeat (gap_n) begin @(posedge CLK); #1; end
      end
      lat = 0;
      while (!m_valid && lat < 20) begin @(posedge CLK); #1; lat++; end
      checks++;
      if (lat !== 3) begin
         errors++;
         $display("FAIL %s latency: got %0d edges, required 3", name, lat);
      end
      checks++;
      if (m_z !== exp_z) begin
         errors++;
         $display("FAIL %s m_z: got %h, required %h", name, m_z, exp_z);
      end
      checks++;
      if ({dsp_shift_right, dsp_round, dsp_saturate, dsp_unsigned_a, dsp_unsigned_b, dsp_feedback, busy}
          !== {f_shift, f_flags[4:1], 3'b000, 1'b1}) begin
         errors++;
         $display("FAIL %s frame_ctrl: got shift=%0d flags=%b fb=%b busy=%b, required shift=%0d flags=%b fb=000 busy=1",
                  name, dsp_shift_right, {dsp_round, dsp_saturate, dsp_unsigned_a, dsp_unsigned_b},
                  dsp_feedback, busy, f_shift, f_flags[4:1]);
      end
      last_z = m_z;
      for (int h = 0; h < hold_n; h++) begin
         @(posedge CLK); #1;
         checks++;
         if (m_valid !== 1'b1 || m_z !== exp_z || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s hold cycle %0d: got m_valid=%b m_z=%h s_ready=%b, required 1 %h 0",
                     name, h, m_valid, m_z, s_ready, exp_z);
         end
      end
      m_ready = 1'b1;
      @(posedge CLK); #1;
      m_ready = 1'b0;
      checks++;
      if (m_valid !== 1'b0 || s_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL %s release: got m_valid=%b s_ready=%b busy=%b, required 0 1 0",
                  name, m_valid, s_ready, busy);
      end
   endtask

   task automatic set_cfg(input int len, input bit sub);
      cfg_len = 8'(len); cfg_subtract = sub; cfg_shift = '0; cfg_round = 1'b0;
      cfg_saturate = 1'b0; cfg_unsigned_a = 1'b0; cfg_unsigned_b = 1'b0;
   endtask

   task automatic check_all_zero(input string name);
      checks++;
      if ({s_ready, busy, m_valid, m_z, dsp_a, dsp_b, dsp_load_acc, dsp_subtract, dsp_shift_right,
           dsp_round, dsp_saturate, dsp_unsigned_a, dsp_unsigned_b, dsp_feedback} !== '0) begin
         errors++;
         $display("FAIL %s outputs_zero: got s_ready=%b busy=%b m_valid=%b m_z=%h dsp_a=%h dsp_b=%h load=%b sub=%b shift=%0d, required all 0",
                  name, s_ready, busy, m_valid, m_z, dsp_a, dsp_b, dsp_load_acc, dsp_subtract, dsp_shift_right);
      end
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      #1;
      check_all_zero("reset");
      repeat (2) @(posedge CLK);
      #1 RESET = 1'b0;
      @(posedge CLK); #1;
      checks++;
      if (s_ready !== 1'b1 || busy !== 1'b0 || dsp_load_acc !== 1'b0) begin
         errors++;
         $display("FAIL reset idle: got s_ready=%b busy=%b load_acc=%b, required 1 0 0", s_ready, busy, dsp_load_acc);
      end
   endtask

   task automatic test_back_to_back();
      set_cfg(4, 1'b0);
      qa = '{20'd1, 20'd2, 20'd3, 20'd4}; qb = '{18'd2, 18'd2, 18'd2, 18'd2};
      run_frame("back_to_back", -1, 0, 1'b0, 0, 1'b0);
      checks++;
      if (last_z !== 38'd20) begin errors++; $display("FAIL back_to_back sum: got %0d, required 20", last_z); end
   endtask

   task automatic test_gaps();
      set_cfg(4, 1'b0);
      qa = '{20'd1, 20'd2, 20'd3, 20'd4}; qb = '{18'd2, 18'd2, 18'd2, 18'd2};
      run_frame("gaps", 1, 3, 1'b0, 0, 1'b0);
      checks++;
      if (last_z !== 38'd20) begin errors++; $display("FAIL gaps sum: got %0d, required 20", last_z); end
   endtask

   task automatic test_subtract();
      set_cfg(3, 1'b1);
      qa = '{20'd10, 20'd3, 20'd2}; qb = '{18'd1, 18'd1, 18'd1};
      run_frame("subtract", -1, 0, 1'b0, 0, 1'b0);
      checks++;
      if (last_z !== 38'd5) begin errors++; $display("FAIL subtract sum: got %0d, required 5", last_z); end
   endtask

   task automatic test_single_beat();
      set_cfg(0, 1'b0);
      qa = '{20'hF_FFF9}; qb = '{18'd3};
      run_frame("single_beat", -1, 0, 1'b0, 0, 1'b0);
      checks++;
      if (last_z !== 38'h3F_FFFF_FFEB) begin
         errors++; $display("FAIL single_beat sum: got %h, required 3fffffffeb", last_z);
      end
   endtask

   task automatic test_backpressure();
      set_cfg(2, 1'b0);
      qa = '{20'd7, 20'd9}; qb = '{18'd3, 18'd1};
      run_frame("backpressure", -1, 0, 1'b0, 10, 1'b0);
   endtask

   task automatic test_reset_midframe();
      set_cfg(4, 1'b0);
      cfg_shift = 6'd5; cfg_round = 1'b1;
      for (int i = 0; i < 2; i++) begin
         s_valid = 1'b1; s_a = 20'(i + 1); s_b = 18'd2;
         @(posedge CLK); #1;
      end
      s_valid = 1'b0;
      RESET = 1'b1;
      #1;
      check_all_zero("reset_midframe");
      repeat (2) @(posedge CLK);
      #1 RESET = 1'b0;
      @(posedge CLK); #1;
      set_cfg(2, 1'b0);
      qa = '{20'd5, 20'd6}; qb = '{18'd1, 18'd1};
      run_frame("after_reset", -1, 0, 1'b0, 0, 1'b0);
      checks++;
      if (last_z !== 38'd11) begin errors++; $display("FAIL after_reset sum: got %0d, required 11", last_z); end
   endtask

   task automatic test_random();
      for (int f = 0; f < 15; f++) begin
         int n;
         cfg_len = 8'($urandom_range(0, 6)); cfg_subtract = 1'($urandom);
         cfg_shift = 6'($urandom); cfg_round = 1'($urandom); cfg_saturate = 1'($urandom);
         cfg_unsigned_a = 1'($urandom); cfg_unsigned_b = 1'($urandom);
         n = (cfg_len == 0) ? 1 : int'(cfg_len);
         qa.delete(); qb.delete();
         for (int i = 0; i < n; i++) begin
            qa.push_back(20'($urandom));
            qb.push_back(18'($urandom));
         end
         run_frame($sformatf("random%0d", f), -1, 0, 1'b1, $urandom_range(0, 3), 1'b1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, required completion");
      $fatal(1);
   end

   initial begin
      RESET = 1'b1; s_valid = 1'b0; s_a = '0; s_b = '0; m_ready = 1'b0;
      set_cfg(1, 1'b0);
      test_reset();
      test_back_to_back();
      test_gaps();
      test_subtract();
      test_single_beat();
      test_backpressure();
      test_reset_midframe();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
